// File: rtl/hybrid_adder_pipe.sv
// Pipelined hybrid lookahead/ripple adder/subtractor: one GROUP-bit CLA slice per
// stage, carries rippling through stage registers, with a valid/ready stream interface.
module hybrid_adder_pipe #(
  parameter int WIDTH = 8,
  parameter int GROUP = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);

  localparam int NG = WIDTH / GROUP;

  if (GROUP < 1 || GROUP > 8 || (WIDTH % GROUP) != 0) begin : g_bad_params
    $error("hybrid_adder_pipe: WIDTH must be a multiple of GROUP, GROUP in 1..8");
  end

  // Flat lookahead: each carry is a sum of products of g/p and the slice carry-in.
  // Returns {carry into slice MSB, slice carry out, slice sum}.
  function automatic logic [GROUP+1:0] cla_slice(input logic [GROUP-1:0] a,
                                                 input logic [GROUP-1:0] b,
                                                 input logic             cin);
    logic [GROUP-1:0] p;
    logic [GROUP-1:0] g;
    logic [GROUP:0]   c;
    logic             term;
    logic             acc;
    p    = a ^ b;
    g    = a & b;
    c    = '0;
    c[0] = cin;
    for (int i = 1; i <= GROUP; i++) begin
      acc = cin;
      for (int j = 0; j < i; j++) acc = acc & p[j];
      for (int j = 0; j < i; j++) begin
        term = g[j];
        for (int m = j + 1; m < i; m++) term = term & p[m];
        acc = acc | term;
      end
      c[i] = acc;
    end
    return {c[GROUP-1], c[GROUP], p ^ c[GROUP-1:0]};
  endfunction

  // Stage k register holds: operand bits not yet consumed (shifted down so the
  // next slice is always at bit 0), the sum assembled so far, its carry and valid.
  logic [WIDTH-1:0] a_q [NG];
  logic [WIDTH-1:0] b_q [NG];
  logic [WIDTH-1:0] s_q [NG];
  logic             c_q [NG];
  logic             v_q [NG];
  logic             ovf_q;

  logic [WIDTH-1:0] a_d [NG];
  logic [WIDTH-1:0] b_d [NG];
  logic [WIDTH-1:0] s_d [NG];
  logic             c_d [NG];
  logic             v_d [NG];
  logic             ovf_d;

  // Handshake: a beat transfers on a side when valid & ready are both high at the
  // rising edge. The output stalls when out_valid & ~out_ready; a stall freezes every
  // stage (bubbles included) and drops in_ready, so inputs are refused that cycle.
  logic stall;
  assign stall    = v_q[NG-1] & ~out_ready;
  assign in_ready = ~stall;

  for (genvar k = 0; k < NG; k++) begin : g_stage
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic [WIDTH-1:0] src_s;
    logic             src_c;
    logic             src_v;
    logic [GROUP+1:0] slice;
    logic [WIDTH-1:0] s_nxt;

    if (k == 0) begin : g_first
      // Subtraction is A + ~B + ~borrow; each beat carries its own conditioning.
      assign src_a = in_a;
      assign src_b = in_sub ? ~in_b : in_b;
      assign src_c = in_cin ^ in_sub;
      assign src_s = '0;
      assign src_v = in_valid;
    end else begin : g_next
      assign src_a = a_q[k-1];
      assign src_b = b_q[k-1];
      assign src_c = c_q[k-1];
      assign src_s = s_q[k-1];
      assign src_v = v_q[k-1];
    end

    assign slice = cla_slice(src_a[GROUP-1:0], src_b[GROUP-1:0], src_c);

    always_comb begin
      s_nxt = src_s;
      s_nxt[k*GROUP +: GROUP] = slice[GROUP-1:0];
    end

    assign a_d[k] = src_a >> GROUP;
    assign b_d[k] = src_b >> GROUP;
    assign s_d[k] = s_nxt;
    assign c_d[k] = slice[GROUP];
    assign v_d[k] = src_v;

    if (k == NG - 1) begin : g_last
      assign ovf_d = slice[GROUP+1] ^ slice[GROUP];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NG; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
        c_q[k] <= 1'b0;
        v_q[k] <= 1'b0;
      end
      ovf_q <= 1'b0;
    end else if (!stall) begin
      for (int k = 0; k < NG; k++) begin
        a_q[k] <= a_d[k];
        b_q[k] <= b_d[k];
        s_q[k] <= s_d[k];
        c_q[k] <= c_d[k];
        v_q[k] <= v_d[k];
      end
      ovf_q <= ovf_d;
    end
  end

  assign out_valid = v_q[NG-1];
  assign out_sum   = s_q[NG-1];
  assign out_cout  = c_q[NG-1];
  assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_hybrid_adder_pipe.sv
// Self-checking bench for hybrid_adder_pipe: directed add/sub cases, a backpressured
// random stream, mid-stream reset and a sweep over other WIDTH/GROUP configurations.
module tb_hybrid_adder_pipe;

  localparam int W  = 8;
  localparam int NG = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- main DUT (8,2) ----------------
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic         in_cin = 1'b0;
  logic         in_sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] out_sum;
  logic         out_cout;
  logic         out_ovf;

  hybrid_adder_pipe #(.WIDTH(8), .GROUP(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sub(in_sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout), .out_ovf(out_ovf)
  );

  // ---------------- sweep DUTs (8,8) (16,4) (32,8) ----------------
  logic        sw_valid = 1'b0;
  logic        sw_oready = 1'b1;
  logic [31:0] sw_a = '0;
  logic [31:0] sw_b = '0;
  logic        sw_cin = 1'b0;
  logic        sw_sub = 1'b0;
  logic        sw_ir0, sw_ir1, sw_ir2;
  logic        sw_ov0, sw_ov1, sw_ov2;
  logic [7:0]  sw_s0;
  logic [15:0] sw_s1;
  logic [31:0] sw_s2;
  logic        sw_co0, sw_co1, sw_co2;
  logic        sw_of0, sw_of1, sw_of2;

  hybrid_adder_pipe #(.WIDTH(8), .GROUP(8)) dut_8_8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(sw_valid), .in_ready(sw_ir0),
    .in_a(sw_a[7:0]), .in_b(sw_b[7:0]), .in_cin(sw_cin), .in_sub(sw_sub),
    .out_valid(sw_ov0), .out_ready(sw_oready),
    .out_sum(sw_s0), .out_cout(sw_co0), .out_ovf(sw_of0)
  );

  hybrid_adder_pipe #(.WIDTH(16), .GROUP(4)) dut_16_4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(sw_valid), .in_ready(sw_ir1),
    .in_a(sw_a[15:0]), .in_b(sw_b[15:0]), .in_cin(sw_cin), .in_sub(sw_sub),
    .out_valid(sw_ov1), .out_ready(sw_oready),
    .out_sum(sw_s1), .out_cout(sw_co1), .out_ovf(sw_of1)
  );

  hybrid_adder_pipe #(.WIDTH(32), .GROUP(8)) dut_32_8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(sw_valid), .in_ready(sw_ir2),
    .in_a(sw_a), .in_b(sw_b), .in_cin(sw_cin), .in_sub(sw_sub),
    .out_valid(sw_ov2), .out_ready(sw_oready),
    .out_sum(sw_s2), .out_cout(sw_co2), .out_ovf(sw_of2)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [33:0] exp_q[$];   // {ovf, cout, sum[31:0]}

  // Reference: integer arithmetic on unsigned and signed interpretations.
  function automatic logic [33:0] ref_add(input int w, input logic [31:0] a,
                                          input logic [31:0] b, input logic cin,
                                          input logic sub);
    longint m, av, bv, cv, full, sa, sb, sr;
    logic co, ov;
    logic [31:0] s;
    m  = longint'(1) << w;
    av = longint'(a) & (m - 1);
    bv = longint'(b) & (m - 1);
    cv = longint'(cin);
    if (sub) begin
      full = av - bv - cv;
      co   = (av >= bv + cv);
    end else begin
      full = av + bv + cv;
      co   = (full >= m);
    end
    s  = 32'(full & (m - 1));
    sa = (av >= m / 2) ? av - m : av;
    sb = (bv >= m / 2) ? bv - m : bv;
    sr = sub ? (sa - sb - cv) : (sa + sb + cv);
    ov = (sr >= m / 2) || (sr < -(m / 2));
    return {ov, co, s};
  endfunction

  // ---------------- driver ----------------
  task automatic send_one(input logic [7:0] a, input logic [7:0] b, input logic cin,
                          input logic sub, output int lat, output logic [7:0] sum,
                          output logic co, output logic ov);
    @(negedge clk);
    in_a = a; in_b = b; in_cin = cin; in_sub = sub;
    in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    in_a = 8'($urandom); in_b = 8'($urandom);
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    sum = out_sum; co = out_cout; ov = out_ovf;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    n_checks++;
    if ({out_valid, out_sum, out_cout, out_ovf} !== 11'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got v=%b sum=%h c=%b o=%b, expected all zero",
               out_valid, out_sum, out_cout, out_ovf);
    end
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_add();
    int lat; logic [7:0] s; logic c, o; logic [33:0] e;
    send_one(8'h3C, 8'h47, 1'b0, 1'b0, lat, s, c, o);
    e = ref_add(8, 32'h3C, 32'h47, 1'b0, 1'b0);
    n_checks++;
    if (lat !== NG) begin
      n_fail++; $display("FAIL add_latency: got %0d expected %0d", lat, NG);
    end
    n_checks++;
    if ({o, c, s} !== {e[33], e[32], e[7:0]}) begin
      n_fail++;
      $display("FAIL add_3c_47: got sum=%h c=%b o=%b expected sum=%h c=%b o=%b",
               s, c, o, e[7:0], e[32], e[33]);
    end
  endtask

  task automatic test_sub();
    int lat; logic [7:0] s; logic c, o; logic [33:0] e;
    logic [7:0] av [2];
    logic [7:0] bv [2];
    av[0] = 8'h10; bv[0] = 8'h20;
    av[1] = 8'h80; bv[1] = 8'h01;
    for (int i = 0; i < 2; i++) begin
      send_one(av[i], bv[i], 1'b0, 1'b1, lat, s, c, o);
      e = ref_add(8, 32'(av[i]), 32'(bv[i]), 1'b0, 1'b1);
      n_checks++;
      if (lat !== NG || {o, c, s} !== {e[33], e[32], e[7:0]}) begin
        n_fail++;
        $display("FAIL sub_%h_%h: got lat=%0d sum=%h c=%b o=%b expected lat=%0d sum=%h c=%b o=%b",
                 av[i], bv[i], lat, s, c, o, NG, e[7:0], e[32], e[33]);
      end
    end
  endtask

  task automatic test_carry_ripple();
    int lat; logic [7:0] s; logic c, o;
    send_one(8'hFF, 8'h00, 1'b1, 1'b0, lat, s, c, o);
    n_checks++;
    if (lat !== NG || {o, c, s} !== {1'b0, 1'b1, 8'h00}) begin
      n_fail++;
      $display("FAIL carry_ripple: got lat=%0d sum=%h c=%b o=%b expected lat=%0d sum=00 c=1 o=0",
               lat, s, c, o, NG);
    end
  endtask

  task automatic test_stream();
    int sent = 0;
    int recv = 0;
    int cyc = 0;
    logic stall_prev = 1'b0;
    logic [7:0] sv_sum = '0;
    logic sv_co = 1'b0, sv_ov = 1'b0;
    logic [33:0] e;
    exp_q.delete();
    while ((sent < 20 || exp_q.size() > 0) && cyc < 600) begin
      @(negedge clk);
      cyc++;
      if (stall_prev) begin
        n_checks++;
        if ({out_valid, out_sum, out_cout, out_ovf} !== {1'b1, sv_sum, sv_co, sv_ov}) begin
          n_fail++;
          $display("FAIL stream_stall_stable: got v=%b sum=%h c=%b o=%b expected v=1 sum=%h c=%b o=%b",
                   out_valid, out_sum, out_cout, out_ovf, sv_sum, sv_co, sv_ov);
        end
      end
      out_ready = ($urandom_range(0, 2) != 0);
      if (sent < 20) begin
        in_valid = 1'b1;
        in_a   = ($urandom_range(0, 4) == 0) ? 8'hFF : 8'($urandom);
        in_b   = 8'($urandom);
        in_cin = 1'($urandom);
        in_sub = 1'($urandom);
      end else begin
        in_valid = 1'b0;
      end
      #1;
      n_checks++;
      if (in_ready !== !(out_valid && !out_ready)) begin
        n_fail++;
        $display("FAIL stream_in_ready: got %b with out_valid=%b out_ready=%b",
                 in_ready, out_valid, out_ready);
      end
      if (out_valid && out_ready) begin
        recv++;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL stream_extra: got unexpected result sum=%h, expected none", out_sum);
        end else begin
          e = exp_q.pop_front();
          if ({out_ovf, out_cout, out_sum} !== {e[33], e[32], e[7:0]}) begin
            n_fail++;
            $display("FAIL stream_result: got sum=%h c=%b o=%b expected sum=%h c=%b o=%b",
                     out_sum, out_cout, out_ovf, e[7:0], e[32], e[33]);
          end
        end
      end
      stall_prev = out_valid && !out_ready;
      sv_sum = out_sum; sv_co = out_cout; sv_ov = out_ovf;
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_add(8, 32'(in_a), 32'(in_b), in_cin, in_sub));
        sent++;
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    n_checks++;
    if (sent != 20 || recv != 20 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL stream_count: got sent=%0d recv=%0d pending=%0d expected 20/20/0",
               sent, recv, exp_q.size());
    end
  endtask

  task automatic test_reset_midstream();
    int k = 0;
    int lat; logic [7:0] s; logic c, o;
    logic stale = 1'b0;
    @(negedge clk);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_a = 8'(i + 5); in_b = 8'(i * 3); in_cin = 1'b0; in_sub = 1'b0;
      in_valid = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    while (!out_valid && k < 10) begin
      @(negedge clk);
      k++;
    end
    n_checks++;
    if (out_valid !== 1'b1) begin
      n_fail++; $display("FAIL midrst_fill: got out_valid=%b expected 1", out_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({out_valid, out_sum, in_ready} !== {1'b0, 8'h00, 1'b1}) begin
      n_fail++;
      $display("FAIL midrst_async: got v=%b sum=%h rdy=%b expected v=0 sum=00 rdy=1",
               out_valid, out_sum, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid) stale = 1'b1;
    end
    n_checks++;
    if (stale !== 1'b0) begin
      n_fail++; $display("FAIL midrst_stale: got stale output=1 expected 0");
    end
    send_one(8'h01, 8'h01, 1'b0, 1'b0, lat, s, c, o);
    n_checks++;
    if (lat !== NG || s !== 8'h02) begin
      n_fail++;
      $display("FAIL midrst_new_beat: got lat=%0d sum=%h expected lat=%0d sum=02", lat, s, NG);
    end
  endtask

  task automatic test_param_sweep();
    int          widths [3];
    int          depths [3];
    logic [33:0] e      [3];
    logic        seen   [3];
    logic        o_v    [3];
    logic [31:0] o_s    [3];
    logic        o_c    [3];
    logic        o_o    [3];
    int lat;
    widths[0] = 8;  depths[0] = 1;
    widths[1] = 16; depths[1] = 4;
    widths[2] = 32; depths[2] = 4;
    sw_oready = 1'b1;
    for (int beat = 0; beat < 24; beat++) begin
      @(negedge clk);
      sw_a   = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
      sw_b   = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      sw_cin = 1'($urandom);
      sw_sub = 1'($urandom);
      sw_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
        e[i] = ref_add(widths[i], sw_a, sw_b, sw_cin, sw_sub);
        seen[i] = 1'b0;
      end
      @(negedge clk);
      sw_valid = 1'b0;
      lat = 1;
      while (lat <= 12 && !(seen[0] && seen[1] && seen[2])) begin
        o_v[0] = sw_ov0; o_s[0] = 32'(sw_s0); o_c[0] = sw_co0; o_o[0] = sw_of0;
        o_v[1] = sw_ov1; o_s[1] = 32'(sw_s1); o_c[1] = sw_co1; o_o[1] = sw_of1;
        o_v[2] = sw_ov2; o_s[2] = sw_s2;      o_c[2] = sw_co2; o_o[2] = sw_of2;
        for (int i = 0; i < 3; i++) begin
          if (!seen[i] && o_v[i]) begin
            seen[i] = 1'b1;
            n_checks++;
            if (lat !== depths[i] || {o_o[i], o_c[i], o_s[i]} !== e[i]) begin
              n_fail++;
              $display("FAIL sweep_w%0d: got lat=%0d sum=%h c=%b o=%b expected lat=%0d sum=%h c=%b o=%b",
                       widths[i], lat, o_s[i], o_c[i], o_o[i], depths[i],
                       e[i][31:0], e[i][32], e[i][33]);
            end
          end
        end
        @(negedge clk);
        lat++;
      end
      for (int i = 0; i < 3; i++) begin
        if (!seen[i]) begin
          n_checks++;
          n_fail++;
          $display("FAIL sweep_w%0d_timeout: got no result expected one after %0d cycles",
                   widths[i], depths[i]);
        end
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_add();
    test_sub();
    test_carry_ripple();
    test_stream();
    test_reset_midstream();
    test_param_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
